// File: rtl/led_code_pkg.sv
// led_code_pkg
// Shared definitions for the LED error-code blinker: FSM state encoding,
// default timing constants, prescaler width and the priority helper used
// by the arbiter.
package led_code_pkg;

    // Prescaler counter width; wide enough for 250 ms at 50 MHz.
    localparam int CNT_W = 25;

    // Default clk cycles per blink tick (250 ms at 50 MHz).
    localparam logic [CNT_W-1:0] DEF_TICK_DIV = 25'd12_500_000;

    // Default number of LED-off ticks between code repetitions.
    localparam logic [3:0] DEF_GAP_TICKS = 4'd4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Index of the lowest set request bit; bit 0 has the highest priority.
    // Returns 3 when only bit 3 is set, or when nothing is set. The caller
    // only uses the result when at least one bit is set.
    function automatic logic [1:0] prio_idx(input logic [3:0] req);
        logic [1:0] idx;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Blink-tick prescaler. While run is high the counter walks 0..TICK_DIV-1
// and wraps; tick is high for the single cycle in which the counter sits at
// TICK_DIV-1. While run is low the counter is held at 0, so the first tick
// after run rises arrives exactly TICK_DIV cycles later.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   run  - enable; low holds the counter at 0
//   tick - one-cycle pulse every TICK_DIV cycles while running
module led_tick_gen
    import led_code_pkg::*;
#(
    parameter logic [CNT_W-1:0] TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = TICK_DIV - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign tick    = run && at_last;

    // Counter next-state: cleared when stopped, wraps at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_code_sched.sv
// led_code_sched
// Reports up to four error sources on one LED as a blink code. The lowest
// pending source index wins; source N blinks N+1 times (ON/OFF of one tick
// each), followed by GAP_TICKS dark ticks. A running code is never
// preempted. With no pending error the LED is steady on once ok_done is set.
//
// Build option: define LED_ALARM_STICKY_EN to latch requests until cleared
// by clr; otherwise requests are used live and clr is ignored.
//
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset
//   err_req  - error requests, bit 0 highest priority
//   ok_done  - operation completed correctly (steady LED when no error)
//   clr      - clears latched errors (sticky build only)
//   led      - [0] code/steady, [1] error pending, [3:2] granted source
//   busy     - high while a code sequence runs
module led_code_sched
    import led_code_pkg::*;
#(
    parameter logic [CNT_W-1:0] TICK_DIV  = DEF_TICK_DIV,
    parameter logic [3:0]       GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] err_req,
    input  logic       ok_done,
    input  logic       clr,
    output logic [3:0] led,
    output logic       busy
);

    logic [3:0] pend;

`ifdef LED_ALARM_STICKY_EN
    // Latched requests. A new request in the same cycle as clr survives.
    logic [3:0] pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~{4{clr}}) | err_req;
        end
    end

    assign pend = pend_q;
`else
    logic unused_clr;

    assign pend       = err_req;
    assign unused_clr = clr;
`endif

    state_e     state_q;
    state_e     state_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;
    logic [2:0] blinks_q;
    logic [2:0] blinks_d;
    logic [3:0] gap_q;
    logic [3:0] gap_d;
    logic [3:0] led_q;
    logic [3:0] led_d;
    logic       busy_q;
    logic       busy_d;
    logic       tick;
    logic       run;

    // Prescaler runs whenever a sequence is active; it sits at 0 in IDLE so
    // every sequence starts with a full-length ON phase.
    assign run = (state_q != IDLE);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // Arbitration and sequencing. Grant and blink count are only loaded in
    // IDLE, which is what makes the code non-preemptive.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        blinks_d = blinks_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (pend != 4'd0) begin
                    grant_d  = prio_idx(pend);
                    blinks_d = {1'b0, grant_d} + 3'd1;
                    gap_d    = 4'd0;
                    state_d  = ON;
                end
            end
            ON: begin
                if (tick) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (tick) begin
                    if (blinks_q > 3'd1) begin
                        blinks_d = blinks_q - 3'd1;
                        state_d  = ON;
                    end else begin
                        blinks_d = 3'd0;
                        gap_d    = 4'd0;
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_TICKS - 4'd1) begin
                        gap_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered LED and
    // busy line up with the state register on the same edge.
    always_comb begin
        busy_d = (state_d != IDLE);
        led_d  = 4'b0000;
        case (state_d)
            ON:      led_d[0] = 1'b1;
            IDLE:    led_d[0] = (pend == 4'd0) && ok_done;
            default: led_d[0] = 1'b0;
        endcase
        led_d[1]   = |pend;
        led_d[3:2] = busy_d ? grant_d : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            blinks_q <= 3'd0;
            gap_q    <= 4'd0;
            led_q    <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            blinks_q <= blinks_d;
            gap_q    <= gap_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_code_sched.sv
// tb_led_code_sched
// Directed bench for led_code_sched with TICK_DIV=4, GAP_TICKS=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The sticky-request scenario is only built when LED_ALARM_STICKY_EN is set.
module tb_led_code_sched;

    logic       clk;
    logic       rst;
    logic [3:0] err_req;
    logic       ok_done;
    logic       clr;
    logic [3:0] led;
    logic       busy;

    int vectorCount = 0;
    int missCount   = 0;

    led_code_sched #(
        .TICK_DIV  (25'd4),
        .GAP_TICKS (4'd2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .err_req (err_req),
        .ok_done (ok_done),
        .clr     (clr),
        .led     (led),
        .busy    (busy)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] err, input logic ok,
                                 input logic clear);
        err_req = err;
        ok_done = ok;
        clr     = clear;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until busy drops, with a cycle budget.
    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            step();
            n++;
        end
        checkOutput("idleReached", {31'd0, busy}, 32'd0);
    endtask

    logic [23:0] pattern26;
    logic        expLed0;

    initial begin
        pattern26 = 24'b1111_0000_1111_0000_0000_0000;
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("resetLed", {28'd0, led}, 32'h0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Steady OK indication.
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step();
        step();
        checkOutput("okLed", {28'd0, led}, 32'h1);
        checkOutput("okBusy", {31'd0, busy}, 32'd0);

        // ok_done low, no error: LED dark.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        step();
        checkOutput("notOkLed", {28'd0, led}, 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step();
        checkOutput("okAgainLed", {28'd0, led}, 32'h1);

        // Source 1 pulsed for one cycle: two blinks then a 2-tick gap.
        applyStimulus(4'b0010, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 24; k++) begin
            checkOutput($sformatf("src1Led0_%0d", k), {31'd0, led[0]},
                        {31'd0, pattern26[23-k]});
            checkOutput($sformatf("src1Grant_%0d", k), {30'd0, led[3:2]}, 32'd1);
            checkOutput($sformatf("src1Busy_%0d", k), {31'd0, busy}, 32'd1);
            if (k < 2) begin
                checkOutput($sformatf("src1Pend_%0d", k), {31'd0, led[1]},
                            (k == 0) ? 32'd1 : 32'd0);
            end
            step();
        end
        checkOutput("src1EndBusy", {31'd0, busy}, 32'd0);
        checkOutput("src1EndLed", {28'd0, led}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            step();
            checkOutput($sformatf("src1NoRepeat_%0d", k), {31'd0, busy}, 32'd0);
        end

        // Source 3 held; source 0 raised during its first ON must wait.
        applyStimulus(4'b1000, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 40; k++) begin
            if (k == 1) begin
                applyStimulus(4'b1001, 1'b1, 1'b0);
            end
            expLed0 = (k < 32) && ((k / 4) % 2 == 0);
            checkOutput($sformatf("src3Led0_%0d", k), {31'd0, led[0]},
                        {31'd0, expLed0});
            checkOutput($sformatf("src3Grant_%0d", k), {30'd0, led[3:2]}, 32'd3);
            checkOutput($sformatf("src3Busy_%0d", k), {31'd0, busy}, 32'd1);
            step();
        end
        checkOutput("src3EndLed", {28'd0, led}, 32'h2);
        checkOutput("src3EndBusy", {31'd0, busy}, 32'd0);
        step();
        checkOutput("src0StartLed", {28'd0, led}, 32'h3);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("src0Led0_%0d", k), {31'd0, led[0]},
                        (k < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("src0Grant_%0d", k), {30'd0, led[3:2]}, 32'd0);
            checkOutput($sformatf("src0Busy_%0d", k), {31'd0, busy}, 32'd1);
            step();
        end
        checkOutput("src0EndBusy", {31'd0, busy}, 32'd0);
        checkOutput("src0EndLed", {28'd0, led}, 32'h1);

        // Two simultaneous requests: the lower index wins.
        applyStimulus(4'b0110, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("prioGrant", {30'd0, led[3:2]}, 32'd1);
        checkOutput("prioBusy", {31'd0, busy}, 32'd1);
        waitIdle(100);

        // Asynchronous reset in the middle of an OFF phase.
        applyStimulus(4'b0001, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
        end
        checkOutput("offLed0", {31'd0, led[0]}, 32'd0);
        checkOutput("offBusy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstLed", {28'd0, led}, 32'h0);
        checkOutput("asyncRstBusy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput($sformatf("postRstBusy_%0d", k), {31'd0, busy}, 32'd0);
        end
        checkOutput("postRstLed", {28'd0, led}, 32'h1);

`ifdef LED_ALARM_STICKY_EN
        // Sticky: a one-cycle request of source 2 keeps repeating.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step();
        checkOutput("stickyStartBusy", {31'd0, busy}, 32'd1);
        checkOutput("stickyStartGrant", {30'd0, led[3:2]}, 32'd2);
        for (int k = 0; k < 32; k++) begin
            step();
        end
        checkOutput("stickyGapEndLed", {28'd0, led}, 32'h2);
        step();
        checkOutput("stickyRepeatBusy", {31'd0, busy}, 32'd1);
        checkOutput("stickyRepeatGrant", {30'd0, led[3:2]}, 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        waitIdle(60);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("stickyClearedBusy_%0d", k), {31'd0, busy}, 32'd0);
        end
        checkOutput("stickyClearedLed", {28'd0, led}, 32'h1);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step();
        checkOutput("setWinsPend", {31'd0, led[1]}, 32'd1);
        checkOutput("setWinsBusy", {31'd0, busy}, 32'd1);
        checkOutput("setWinsGrant", {30'd0, led[3:2]}, 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        waitIdle(60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
